wb_fib_array: RTL and testbench
===============================

Name: wb_fib_array

Overview:
- Wishbone-slave peripheral holding NUM_CH independent, WIDTH-bit generalised Fibonacci generators.
- Each channel has programmable seeds, free-run or single-step mode, and overflow detection with halt-or-wrap policy.
- Sticky overflow status drives a maskable interrupt.
- Sits in the user project area on the management Wishbone bus; generator values are also exported as a flat bus for pads or the logic analyser.

Parameters:
- BASE_ADDRESS, 24'h030000: match value for wbs_adr_i[31:8].
- NUM_CH, 4: generator channels, range 1..4.
- WIDTH, 30: generator width in bits, range 2..32.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- value_o  out  NUM_CH*WIDTH  current b register of each channel; channel 0 in the LSBs.
- irq_o  out  1  OR of (IRQ_STAT & IRQ_EN).

Behaviour:
- **Reset values:**
  - all outputs 0;
  - channel a=0, b=0;
  - seeds 0 and 1;
  - CTRL=0, IRQ_STAT=0, IRQ_EN=0.
- **Address decode:** hit = stb & cyc & (adr[31:8]==BASE_ADDRESS).
- **Ack timing:**
  - wbs_ack_o is registered: it rises the cycle after a hit while ack is low, and is held for exactly 1 cycle.
  - Back-to-back hits therefore ack every other cycle.
  - All hits are acked, including unmapped offsets, which read 0 and ignore writes.
- **Write qualification:** a write commits on the ack cycle only when wbs_sel_i==4'hF; partial-select writes are acked and dropped.
- **Read data:** wbs_dat_o is registered alongside ack and is 0 when not acking.
- **Register map** (offset = adr[7:0]):
  - 0x00 ID: RO, 32'h4669626f.
  - 0x04 CFG: RO, {16'h0, NUM_CH[7:0], WIDTH[7:0]}.
  - 0x08 IRQ_STAT: bit ch sticky; write-1-to-clear.
  - 0x0C IRQ_EN: bits [NUM_CH-1:0], R/W.
  - 0x10+0x10*ch CTRL:
    - bit0 EN, bit1 STEP_MODE, bit2 WRAP: R/W.
    - bit3 RELOAD, bit4 STEP: write-only strobes, read 0.
  - 0x14+0x10*ch SEED_A: R/W, low WIDTH bits.
  - 0x18+0x10*ch SEED_B: R/W, low WIDTH bits.
  - 0x1C+0x10*ch VALUE: RO, zero-extended b.
  - Channel offsets with ch>=NUM_CH are unmapped.
- **Advance event:**
  - In free-run mode (EN=1, STEP_MODE=0), a channel advances every cycle.
  - In step mode (EN=1, STEP_MODE=1), it advances once per CTRL write with STEP=1.
- **Advance computation:** sum = a+b computed in WIDTH+1 bits.
  - If sum[WIDTH]=0: a<=b, b<=sum[WIDTH-1:0].
  - If sum[WIDTH]=1 (overflow):
    - IRQ_STAT[ch]<=1.
    - WRAP=0: a and b hold, EN<=0 (channel halts at its last valid value).
    - WRAP=1: a<=SEED_A, b<=SEED_B; EN stays 1.
- **RELOAD strobe:** a<=SEED_A, b<=SEED_B, regardless of EN.
- **Simultaneous events:**
  - RELOAD beats STEP and free-run advance in the same write.
  - A bus write to CTRL.EN beats the overflow auto-clear in the same cycle.
  - Overflow set of IRQ_STAT beats W1C clear in the same cycle.
  - Seed writes take effect from the next reload, not retroactively.
- **Reset mid-operation:** asynchronous reset returns everything to reset values immediately.
  - A pending ack is dropped.
  - The master must retry.

Decomposition:
- **Package fib_array_pkg:**
  - register offsets: ID, CFG, IRQ_STAT, IRQ_EN, CH_BASE, CH_STRIDE, CTRL/SEED_A/SEED_B/VALUE;
  - CTRL bit indices;
  - ID constant 32'h4669626f.
- **Sub-module fib_channel:**
  - parameter WIDTH;
  - ports: clk, async reset, en, step_mode, wrap, step_pulse, reload_pulse, seed_a, seed_b;
  - outputs: value, overflow_pulse, halt_pulse.
- The top level instantiates NUM_CH copies with generate and owns the bus, CTRL, IRQ and seed registers.

Test Plan:
1. Reset, then read 0x00 and 0x04 with NUM_CH=4, WIDTH=8 -> 32'h4669626f and 32'h00000408; each ack is 1 cycle wide and 1 cycle after stb.
2. WIDTH=8, ch0 seeds 0/1, RELOAD, then CTRL=EN -> VALUE sequence 1,1,2,3,5,…,233 over 12 cycles; next cycle overflows; VALUE holds 233; CTRL.EN reads 0; IRQ_STAT=1; irq_o=0 until IRQ_EN[0]=1, then irq_o=1.
3. Same as scenario 2 with WRAP=1 -> after 233, b returns to 1, a to 0, channel keeps running; IRQ_STAT[0] set; W1C write 0x1 clears it.
4. ch1 STEP_MODE=1, seeds 3/4: three CTRL writes with EN|STEP_MODE|STEP -> VALUE 7, 11, 18; no change between writes.
5. Write CTRL with RELOAD|STEP both set on ch1 after scenario 4 -> VALUE returns to 4, no advance; partial write (sel=4'h3) to SEED_A -> acked, register unchanged.
6. Read 0x50 with NUM_CH=4 and 0xFC -> ack, data 0; assert wb_rst_i during an outstanding ack -> ack and value_o drop to 0 asynchronously.

Source files
------------

// File: rtl/fib_array_pkg.sv
// Shared register map, CTRL bit positions and decode helpers for the
// Wishbone Fibonacci generator array.
package fib_array_pkg;

   localparam logic [7:0]  ID_OFF       = 8'h00;
   localparam logic [7:0]  CFG_OFF      = 8'h04;
   localparam logic [7:0]  IRQ_STAT_OFF = 8'h08;
   localparam logic [7:0]  IRQ_EN_OFF   = 8'h0C;
   localparam logic [7:0]  CH_BASE      = 8'h10;
   localparam logic [7:0]  CH_STRIDE    = 8'h10;

   localparam logic [3:0]  CTRL_OFF     = 4'h0;
   localparam logic [3:0]  SEED_A_OFF   = 4'h4;
   localparam logic [3:0]  SEED_B_OFF   = 4'h8;
   localparam logic [3:0]  VALUE_OFF    = 4'hC;

   localparam int          CTRL_EN        = 0;
   localparam int          CTRL_STEP_MODE = 1;
   localparam int          CTRL_WRAP      = 2;
   localparam int          CTRL_RELOAD    = 3;
   localparam int          CTRL_STEP      = 4;

   localparam logic [31:0] ID_VALUE     = 32'h4669626f;

   // Channel slot of a byte offset; only meaningful when offset >= CH_BASE.
   function automatic logic [3:0] ch_slot(input logic [7:0] off);
      ch_slot = off[7:4] - CH_BASE[7:4];
   endfunction

endpackage

// File: rtl/fib_array_channel.sv
// One generalised Fibonacci generator: a<=b, b<=a+b per advance, with
// reload, overflow detection and halt-or-wrap handling.
module fib_channel
   import fib_array_pkg::*;
#(
   parameter int WIDTH = 30
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             step_mode,
   input  logic             wrap,
   input  logic             step_pulse,
   input  logic             reload_pulse,
   input  logic [WIDTH-1:0] seed_a,
   input  logic [WIDTH-1:0] seed_b,
   output logic [WIDTH-1:0] value,
   output logic             overflow_pulse,
   output logic             halt_pulse
);

   logic [WIDTH-1:0] a_r, b_r, a_nxt_s, b_nxt_s;
   logic [WIDTH:0]   sum_s;
   logic             advance_s;

   assign sum_s     = {1'b0, a_r} + {1'b0, b_r};
   assign advance_s = en & (step_mode ? step_pulse : 1'b1);
   assign value     = b_r;

   // Next-state selection: reload has priority over any advance.
   always_comb begin
      a_nxt_s        = a_r;
      b_nxt_s        = b_r;
      overflow_pulse = 1'b0;
      halt_pulse     = 1'b0;
      if (reload_pulse) begin
         a_nxt_s = seed_a;
         b_nxt_s = seed_b;
      end else if (advance_s) begin
         if (!sum_s[WIDTH]) begin
            a_nxt_s = b_r;
            b_nxt_s = sum_s[WIDTH-1:0];
         end else begin
            overflow_pulse = 1'b1;
            if (wrap) begin
               a_nxt_s = seed_a;
               b_nxt_s = seed_b;
            end else begin
               halt_pulse = 1'b1;
            end
         end
      end else begin
         a_nxt_s = a_r;
         b_nxt_s = b_r;
      end
   end

   // Generator state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r <= {WIDTH{1'b0}};
         b_r <= {WIDTH{1'b0}};
      end else begin
         a_r <= a_nxt_s;
         b_r <= b_nxt_s;
      end
   end

endmodule

// File: rtl/wb_fib_array.sv
// Wishbone slave wrapping NUM_CH Fibonacci channels: bus decode, CTRL/seed
// registers, sticky overflow status and maskable interrupt.
module wb_fib_array
   import fib_array_pkg::*;
#(
   parameter logic [23:0] BASE_ADDRESS = 24'h030000,
   parameter int          NUM_CH       = 4,
   parameter int          WIDTH        = 30
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    wbs_stb_i,
   input  logic                    wbs_cyc_i,
   input  logic                    wbs_we_i,
   input  logic [3:0]              wbs_sel_i,
   input  logic [31:0]             wbs_dat_i,
   input  logic [31:0]             wbs_adr_i,
   output logic                    wbs_ack_o,
   output logic [31:0]             wbs_dat_o,
   output logic [NUM_CH*WIDTH-1:0] value_o,
   output logic                    irq_o
);

   logic              ack_r, irq_r;
   logic [31:0]       dat_r, rd_s;
   logic              hit_s, accept_s, wr_s, ch_hit_s;
   logic [7:0]        off_s;
   logic [3:0]        slot_s, field_s;
   logic [NUM_CH-1:0] irq_stat_r, irq_en_r, stat_clr_s, ovf_v, sel_v;
   logic [31:0]       ch_rd_a [NUM_CH];
   logic              unused_bits;

   assign hit_s    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDRESS);
   assign accept_s = hit_s & ~ack_r;
   assign wr_s     = accept_s & wbs_we_i & (wbs_sel_i == 4'hF);
   assign off_s    = wbs_adr_i[7:0];
   assign slot_s   = ch_slot(off_s);
   assign field_s  = off_s[3:0];
   assign ch_hit_s = (off_s >= CH_BASE) && (int'(slot_s) < NUM_CH);
   assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i};

   assign stat_clr_s = (wr_s && (off_s == IRQ_STAT_OFF)) ? wbs_dat_i[NUM_CH-1:0]
                                                         : {NUM_CH{1'b0}};

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic             sel_s, wr_ctrl_s, en_r, step_mode_r, wrap_r, halt_s;
      logic [WIDTH-1:0] seed_a_r, seed_b_r, value_s;
      logic [31:0]      ch_rd_s;

      assign sel_s     = ch_hit_s && (slot_s == 4'(g));
      assign wr_ctrl_s = wr_s && sel_s && (field_s == CTRL_OFF);

      // A CTRL write acts in its own commit cycle, so the channel sees the new bits.
      fib_channel #(.WIDTH(WIDTH)) u_fib (
         .clk            (wb_clk_i),
         .rst            (wb_rst_i),
         .en             (wr_ctrl_s ? wbs_dat_i[CTRL_EN]        : en_r),
         .step_mode      (wr_ctrl_s ? wbs_dat_i[CTRL_STEP_MODE] : step_mode_r),
         .wrap           (wr_ctrl_s ? wbs_dat_i[CTRL_WRAP]      : wrap_r),
         .step_pulse     (wr_ctrl_s & wbs_dat_i[CTRL_STEP]),
         .reload_pulse   (wr_ctrl_s & wbs_dat_i[CTRL_RELOAD]),
         .seed_a         (seed_a_r),
         .seed_b         (seed_b_r),
         .value          (value_s),
         .overflow_pulse (ovf_v[g]),
         .halt_pulse     (halt_s)
      );

      // CTRL and seed registers; a bus EN write wins over the halt auto-clear.
      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
         if (wb_rst_i) begin
            en_r        <= 1'b0;
            step_mode_r <= 1'b0;
            wrap_r      <= 1'b0;
            seed_a_r    <= {WIDTH{1'b0}};
            seed_b_r    <= {{(WIDTH-1){1'b0}}, 1'b1};
         end else begin
            if (wr_ctrl_s) begin
               en_r        <= wbs_dat_i[CTRL_EN];
               step_mode_r <= wbs_dat_i[CTRL_STEP_MODE];
               wrap_r      <= wbs_dat_i[CTRL_WRAP];
            end else if (halt_s) begin
               en_r <= 1'b0;
            end
            if (wr_s && sel_s && (field_s == SEED_A_OFF)) seed_a_r <= wbs_dat_i[WIDTH-1:0];
            if (wr_s && sel_s && (field_s == SEED_B_OFF)) seed_b_r <= wbs_dat_i[WIDTH-1:0];
         end
      end

      // Per-channel read word.
      always_comb begin
         ch_rd_s = 32'h0;
         case (field_s)
            CTRL_OFF: begin
               ch_rd_s[CTRL_EN]        = en_r;
               ch_rd_s[CTRL_STEP_MODE] = step_mode_r;
               ch_rd_s[CTRL_WRAP]      = wrap_r;
            end
            SEED_A_OFF: ch_rd_s[WIDTH-1:0] = seed_a_r;
            SEED_B_OFF: ch_rd_s[WIDTH-1:0] = seed_b_r;
            VALUE_OFF:  ch_rd_s[WIDTH-1:0] = value_s;
            default:    ch_rd_s = 32'h0;
         endcase
      end

      assign sel_v[g]   = sel_s;
      assign ch_rd_a[g] = ch_rd_s;
      assign value_o[g*WIDTH +: WIDTH] = value_s;
   end

   // Read mux; unmapped offsets fall through to zero.
   always_comb begin
      rd_s = 32'h0;
      case (off_s)
         ID_OFF:       rd_s = ID_VALUE;
         CFG_OFF:      rd_s = {16'h0, 8'(NUM_CH), 8'(WIDTH)};
         IRQ_STAT_OFF: rd_s[NUM_CH-1:0] = irq_stat_r;
         IRQ_EN_OFF:   rd_s[NUM_CH-1:0] = irq_en_r;
         default: begin
            for (int i = 0; i < NUM_CH; i++) begin
               rd_s = rd_s | (sel_v[i] ? ch_rd_a[i] : 32'h0);
            end
         end
      endcase
   end

   // Bus response, interrupt status and interrupt output registers.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_r      <= 1'b0;
         dat_r      <= 32'h0;
         irq_stat_r <= {NUM_CH{1'b0}};
         irq_en_r   <= {NUM_CH{1'b0}};
         irq_r      <= 1'b0;
      end else begin
         ack_r      <= accept_s;
         dat_r      <= (accept_s & ~wbs_we_i) ? rd_s : 32'h0;
         irq_stat_r <= (irq_stat_r & ~stat_clr_s) | ovf_v;
         if (wr_s && (off_s == IRQ_EN_OFF)) irq_en_r <= wbs_dat_i[NUM_CH-1:0];
         irq_r      <= |(irq_stat_r & irq_en_r);
      end
   end

   assign wbs_ack_o = ack_r;
   assign wbs_dat_o = dat_r;
   assign irq_o     = irq_r;

endmodule

// File: tb/tb_wb_fib_array.sv
// Directed self-checking bench for wb_fib_array (NUM_CH=4, WIDTH=8).
module tb_wb_fib_array;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] dat = 32'h0, adr = 32'h0;
   logic        ack;
   logic [31:0] rdat;
   logic [31:0] value;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;
   int fib_seq [12] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};

   wb_fib_array #(.BASE_ADDRESS(24'h030000), .NUM_CH(4), .WIDTH(8)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_dat_i (dat),
      .wbs_adr_i (adr),
      .wbs_ack_o (ack),
      .wbs_dat_o (rdat),
      .value_o   (value),
      .irq_o     (irq)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ba(input logic [7:0] off);
      ba = {24'h030000, off};
   endfunction

   task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output int lat, output bit ok);
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; adr = a; dat = 32'h0;
      ok = 1'b0; lat = 0; d = 32'h0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk);
         lat = lat + 1;
         if (ack === 1'b1) begin
            ok = 1'b1;
            d  = rdat;
         end
      end
      stb = 1'b0; cyc = 1'b0;
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output bit ok);
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = s; adr = a; dat = d;
      ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk);
         if (ack === 1'b1) ok = 1'b1;
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d; int lat; bit ok;
      repeat (2) @(negedge clk);
      n_checks++; if ({ack, rdat, irq, value} !== 66'h0) begin n_fail++; $display("FAIL reset_outputs: got ack=%b dat=%h irq=%b value=%h required all 0", ack, rdat, irq, value); end
      rst = 1'b0;
      wb_read(ba(8'h00), d, lat, ok);
      n_checks++; if (d !== 32'h4669626f || !ok) begin n_fail++; $display("FAIL id_read: got %h ok=%b required 4669626f", d, ok); end
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL ack_latency: got %0d cycles required 1", lat); end
      @(negedge clk);
      n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL ack_width: ack still %b one cycle later, required 0", ack); end
      wb_read(ba(8'h04), d, lat, ok);
      n_checks++; if (d !== 32'h00000408 || lat !== 1) begin n_fail++; $display("FAIL cfg_read: got %h lat=%0d required 00000408 lat=1", d, lat); end
      wb_read(ba(8'h18), d, lat, ok);
      n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL seed_b_reset: got %h required 00000001", d); end
      wb_read(ba(8'h1C), d, lat, ok);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL value_reset: got %h required 0", d); end
   endtask

   task automatic test_free_run_halt();
      logic [31:0] d; int lat; bit ok;
      wb_write(ba(8'h10), 32'h08, 4'hF, ok);
      n_checks++; if (value[7:0] !== 8'd1) begin n_fail++; $display("FAIL reload_ch0: got %0d required 1", value[7:0]); end
      wb_write(ba(8'h10), 32'h01, 4'hF, ok);
      for (int i = 0; i < 12; i++) begin
         if (i != 0) @(negedge clk);
         n_checks++; if (value[7:0] !== 8'(fib_seq[i])) begin n_fail++; $display("FAIL free_run_seq[%0d]: got %0d required %0d", i, value[7:0], fib_seq[i]); end
      end
      repeat (3) @(negedge clk);
      n_checks++; if (value[7:0] !== 8'd233) begin n_fail++; $display("FAIL halt_hold: got %0d required 233", value[7:0]); end
      wb_read(ba(8'h10), d, lat, ok);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL halt_en_clear: CTRL got %h required 0", d); end
      wb_read(ba(8'h08), d, lat, ok);
      n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL halt_irq_stat: got %h required 1", d); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b required 0", irq); end
      wb_write(ba(8'h0C), 32'h1, 4'hF, ok);
      @(negedge clk);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_enabled: got %b required 1", irq); end
   endtask

   task automatic test_wrap();
      logic [31:0] d; int lat; bit ok;
      wb_write(ba(8'h08), 32'h1, 4'hF, ok);
      wb_read(ba(8'h08), d, lat, ok);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_pre: got %h required 0", d); end
      wb_write(ba(8'h10), 32'h0C, 4'hF, ok);
      n_checks++; if (value[7:0] !== 8'd1) begin n_fail++; $display("FAIL wrap_reload: got %0d required 1", value[7:0]); end
      wb_write(ba(8'h10), 32'h05, 4'hF, ok);
      for (int i = 1; i < 12; i++) @(negedge clk);
      n_checks++; if (value[7:0] !== 8'd233) begin n_fail++; $display("FAIL wrap_peak: got %0d required 233", value[7:0]); end
      @(negedge clk);
      n_checks++; if (value[7:0] !== 8'd1) begin n_fail++; $display("FAIL wrap_to_seed: got %0d required 1", value[7:0]); end
      @(negedge clk);
      n_checks++; if (value[7:0] !== 8'd1) begin n_fail++; $display("FAIL wrap_run1: got %0d required 1", value[7:0]); end
      @(negedge clk);
      n_checks++; if (value[7:0] !== 8'd2) begin n_fail++; $display("FAIL wrap_run2: got %0d required 2", value[7:0]); end
      wb_write(ba(8'h10), 32'h04, 4'hF, ok);
      wb_read(ba(8'h08), d, lat, ok);
      n_checks++; if (d !== 32'h1 || irq !== 1'b1) begin n_fail++; $display("FAIL wrap_irq_stat: got stat=%h irq=%b required 1/1", d, irq); end
      wb_write(ba(8'h08), 32'h1, 4'hF, ok);
      wb_read(ba(8'h08), d, lat, ok);
      n_checks++; if (d !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL w1c_clear: got stat=%h irq=%b required 0/0", d, irq); end
   endtask

   task automatic test_step_mode();
      logic [31:0] d; int lat; bit ok;
      logic [7:0] exp [3];
      exp[0] = 8'd7; exp[1] = 8'd11; exp[2] = 8'd18;
      wb_write(ba(8'h24), 32'h3, 4'hF, ok);
      wb_write(ba(8'h28), 32'h4, 4'hF, ok);
      wb_write(ba(8'h20), 32'h08, 4'hF, ok);
      wb_read(ba(8'h2C), d, lat, ok);
      n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL step_reload: got %h required 4", d); end
      for (int i = 0; i < 3; i++) begin
         wb_write(ba(8'h20), 32'h13, 4'hF, ok);
         repeat (4) @(negedge clk);
         n_checks++; if (value[15:8] !== exp[i]) begin n_fail++; $display("FAIL step_value[%0d]: got %0d required %0d", i, value[15:8], exp[i]); end
      end
      wb_read(ba(8'h2C), d, lat, ok);
      n_checks++; if (d !== 32'd18) begin n_fail++; $display("FAIL step_value_reg: got %0d required 18", d); end
   endtask

   task automatic test_reload_priority();
      logic [31:0] d; int lat; bit ok;
      wb_write(ba(8'h20), 32'h1B, 4'hF, ok);
      repeat (2) @(negedge clk);
      n_checks++; if (value[15:8] !== 8'd4) begin n_fail++; $display("FAIL reload_beats_step: got %0d required 4", value[15:8]); end
      wb_read(ba(8'h20), d, lat, ok);
      n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL ctrl_strobes_read0: got %h required 3", d); end
      wb_write(ba(8'h24), 32'h55, 4'h3, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL partial_ack: got ok=%b required 1", ok); end
      wb_read(ba(8'h24), d, lat, ok);
      n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL partial_dropped: got %h required 3", d); end
   endtask

   task automatic test_unmapped_reset();
      logic [31:0] d; int lat; bit ok;
      wb_read(ba(8'h50), d, lat, ok);
      n_checks++; if (!ok || d !== 32'h0) begin n_fail++; $display("FAIL unmapped_50: got ok=%b data=%h required 1/0", ok, d); end
      wb_read(ba(8'hFC), d, lat, ok);
      n_checks++; if (!ok || d !== 32'h0) begin n_fail++; $display("FAIL unmapped_fc: got ok=%b data=%h required 1/0", ok, d); end
      wb_read(32'h0003_1000, d, lat, ok);
      n_checks++; if (ok) begin n_fail++; $display("FAIL base_miss: got ack=1 required no ack"); end
      wb_write(ba(8'h10), 32'h05, 4'hF, ok);
      repeat (3) @(negedge clk);
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; adr = ba(8'h00);
      @(posedge clk); #1;
      n_checks++; if (ack !== 1'b1 || value === 32'h0) begin n_fail++; $display("FAIL pre_reset_ack: got ack=%b value=%h required ack=1 value!=0", ack, value); end
      #1 rst = 1'b1;
      #1;
      n_checks++; if (ack !== 1'b0 || rdat !== 32'h0 || value !== 32'h0) begin n_fail++; $display("FAIL async_reset: got ack=%b dat=%h value=%h required 0/0/0", ack, rdat, value); end
      stb = 1'b0; cyc = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      wb_read(ba(8'h00), d, lat, ok);
      n_checks++; if (d !== 32'h4669626f || lat !== 1) begin n_fail++; $display("FAIL retry_after_reset: got %h lat=%0d required 4669626f lat=1", d, lat); end
   endtask

   initial begin
      test_reset();
      test_free_run_halt();
      test_wrap();
      test_step_mode();
      test_reload_priority();
      test_unmapped_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
